change_dispenser: RTL
=====================

Name: change_dispenser

Overview:
- Payout end of the vending machine's money path; the coin detector handles money coming in, this block pays change back out.
- Takes the change amount computed by the controller and drives a two-tube coin hopper one coin at a time.
- Uses greedy big-coin-first selection, a per-coin eject/acknowledge handshake and an ack timeout.
- Tracks per-tube coin inventory and reports progress and faults for the display modules.

Parameters:
- BIG_VALUE, 5, value in yuan of one big coin; unit coin is fixed at 1 yuan.
- EJECT_CYCLES, 4, eject pulse width in clk cycles, at least 1.
- ACK_TIMEOUT, 1000, cycles spent in WAIT_ACK without an ack before a fault is raised.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; accepted only in IDLE.
- change_amount  in  8  amount to pay in yuan; sampled on an accepted start.
- inv_load  in  1  loads both tube counts; accepted only in IDLE.
- inv_big_in  in  8  big-tube count to load.
- inv_small_in  in  8  unit-tube count to load.
- hopper_ack  in  1  coin-passed sensor, level; rising edge detected internally.
- fault_clr  in  1  leaves FAULT for IDLE.
- eject_big  out  1  eject pulse for the big tube.
- eject_small  out  1  eject pulse for the unit tube.
- busy  out  1  high in SELECT, EJECT and WAIT_ACK.
- done  out  1  one-cycle completion pulse.
- fault  out  1  high while in FAULT.
- fault_type  out  2  01 = insufficient inventory, 10 = ack timeout, 00 = none.
- remaining  out  8  amount still unpaid.
- coins_paid  out  8  coins ejected in the current payout.
- inv_big  out  8  current big-tube count.
- inv_small  out  8  current unit-tube count.

Behaviour:
- Reset values: every output is 0. Inventory is 0, state is IDLE, timers and the edge detector are cleared. Reset applied mid-operation takes effect the next cycle; any eject line drops immediately and nothing is resumed.
- All outputs are registered.
- FSM states: IDLE, SELECT, EJECT, WAIT_ACK, DONE, FAULT.
- IDLE, inv_load=1: load inv_big/inv_small. inv_load has priority over a simultaneous start, which is dropped.
- IDLE, start=1: latch remaining=change_amount and clear coins_paid, then branch:
  - change_amount==0 -> DONE.
  - Feasibility fails -> FAULT, fault_type=01. Feasibility test: b = min(amount/BIG_VALUE, inv_big), r = amount - b*BIG_VALUE, require r <= inv_small. On this fault no coin is ejected and inventory is unchanged.
  - Otherwise -> SELECT.
- SELECT (1 cycle):
  - remaining==0 -> DONE.
  - Else pick big if remaining >= BIG_VALUE and inv_big != 0, otherwise pick unit. Feasibility guarantees the chosen tube is non-empty.
  - -> EJECT.
- EJECT: the selected eject line is high for exactly EJECT_CYCLES cycles; the other line stays 0. Then -> WAIT_ACK with the timer cleared.
- WAIT_ACK:
  - On a hopper_ack rising edge: subtract the coin value from remaining, decrement the matching inventory count, increment coins_paid, -> SELECT.
  - If the timer reaches ACK_TIMEOUT: -> FAULT, fault_type=10. remaining and inventory keep their pre-coin values.
  - Ack edges in any other state are ignored.
- DONE: done=1 for one cycle, busy=0, -> IDLE. remaining (0) and coins_paid hold until the next start.
- FAULT: fault=1, eject lines low, busy=0. Holds until fault_clr=1, then -> IDLE with fault_type cleared. start is ignored while in FAULT.
- start, inv_load and fault_clr outside their accepting states have no effect.
- Arithmetic is 8-bit unsigned; no wrap is possible because feasibility is checked before the first eject.
- Timing:
  - busy rises the cycle after an accepted start.
  - Each coin takes 1 (SELECT) + EJECT_CYCLES + ack delay cycles.

Test Plan:
- Load big=3/small=10, start amount=12, ack 2 cycles after each pulse end -> eject sequence big, big, small, small; each pulse 4 cycles wide; done pulse; remaining=0, coins_paid=4, inv 1/8.
- Load big=1/small=10, amount=13 -> 1 big then 8 small; coins_paid=9; inv 0/2; done.
- Load big=0/small=3, amount=7 -> next cycle fault=1, fault_type=01, no eject, remaining=7, inv 0/3. fault_clr -> IDLE, fault=0.
- Amount=0 -> done high exactly one cycle after start, no eject, busy never high.
- Load big=2, amount=5, hold hopper_ack low -> one 4-cycle eject_big, then fault_type=10 after 1000 WAIT_ACK cycles; remaining=5, inv_big=2, eject lines low.
- Assert reset during WAIT_ACK of the 2nd coin -> next cycle all outputs 0 and state IDLE. A later start with zero inventory and amount=3 -> fault_type=01.

Source files
------------

// File: rtl/change_dispenser.sv
// change_dispenser: pays change out of a two-tube coin hopper one coin at a time.
// Coins are chosen big-first. Each coin gets a fixed-width eject pulse and then
// waits for the hopper's coin-passed sensor. The block keeps a per-tube coin
// inventory and reports progress and faults. Every output comes from a flop.
module change_dispenser #(
  parameter int BIG_VALUE    = 5,
  parameter int EJECT_CYCLES = 4,
  parameter int ACK_TIMEOUT  = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] change_amount,
  input  logic       inv_load,
  input  logic [7:0] inv_big_in,
  input  logic [7:0] inv_small_in,
  input  logic       hopper_ack,
  input  logic       fault_clr,
  output logic       eject_big,
  output logic       eject_small,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [1:0] fault_type,
  output logic [7:0] remaining,
  output logic [7:0] coins_paid,
  output logic [7:0] inv_big,
  output logic [7:0] inv_small
);

  localparam int EW = (EJECT_CYCLES > 1) ? $clog2(EJECT_CYCLES) : 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [7:0]    BIG_V   = 8'(BIG_VALUE);
  localparam logic [EW-1:0] EJ_LAST = EW'(EJECT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);

  localparam logic [1:0] FT_NONE    = 2'b00;
  localparam logic [1:0] FT_INV     = 2'b01;
  localparam logic [1:0] FT_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    EJECT,
    WAIT_ACK,
    DONE,
    FAULT
  } state_t;

  state_t        state, state_n;
  logic          sel_big, sel_big_n;
  logic [EW-1:0] eject_cnt, eject_cnt_n;
  logic [TW-1:0] ack_timer, ack_timer_n;
  logic          ack_prev;
  logic          ack_edge;

  logic [7:0]    remaining_n, coins_paid_n, inv_big_n, inv_small_n;
  logic [1:0]    fault_type_n;
  logic          eject_big_n, eject_small_n, busy_n, done_n, fault_n;

  // feasibility of a requested amount against the current inventory
  logic [7:0]    big_fit, big_use, small_need;
  logic          feasible;

  assign ack_edge = hopper_ack & ~ack_prev;

  // Greedy feasibility: use as many big coins as fit and are stocked,
  // the rest must be covered by the unit tube.
  always_comb begin
    big_fit    = change_amount / BIG_V;
    big_use    = (big_fit < inv_big) ? big_fit : inv_big;
    small_need = change_amount - 8'(big_use * BIG_V);
    feasible   = (small_need <= inv_small);
  end

  // Next-state and next-register values; outputs are decoded from the next
  // state so that they land in flops aligned with the state register.
  always_comb begin
    state_n      = state;
    sel_big_n    = sel_big;
    eject_cnt_n  = eject_cnt;
    ack_timer_n  = ack_timer;
    remaining_n  = remaining;
    coins_paid_n = coins_paid;
    inv_big_n    = inv_big;
    inv_small_n  = inv_small;
    fault_type_n = fault_type;

    case (state)
      IDLE: begin
        if (inv_load) begin
          inv_big_n   = inv_big_in;
          inv_small_n = inv_small_in;
        end else if (start) begin
          remaining_n  = change_amount;
          coins_paid_n = 8'd0;
          if (change_amount == 8'd0) begin
            state_n = DONE;
          end else if (!feasible) begin
            state_n      = FAULT;
            fault_type_n = FT_INV;
          end else begin
            state_n = SELECT;
          end
        end
      end

      SELECT: begin
        if (remaining == 8'd0) begin
          state_n = DONE;
        end else begin
          sel_big_n   = (remaining >= BIG_V) && (inv_big != 8'd0);
          eject_cnt_n = '0;
          state_n     = EJECT;
        end
      end

      EJECT: begin
        if (eject_cnt == EJ_LAST) begin
          ack_timer_n = '0;
          state_n     = WAIT_ACK;
        end else begin
          eject_cnt_n = eject_cnt + EW'(1);
        end
      end

      WAIT_ACK: begin
        if (ack_edge) begin
          if (sel_big) begin
            remaining_n = remaining - BIG_V;
            inv_big_n   = inv_big - 8'd1;
          end else begin
            remaining_n = remaining - 8'd1;
            inv_small_n = inv_small - 8'd1;
          end
          coins_paid_n = coins_paid + 8'd1;
          state_n      = SELECT;
        end else if (ack_timer == TO_LAST) begin
          state_n      = FAULT;
          fault_type_n = FT_TIMEOUT;
        end else begin
          ack_timer_n = ack_timer + TW'(1);
        end
      end

      DONE: begin
        state_n = IDLE;
      end

      FAULT: begin
        if (fault_clr) begin
          state_n      = IDLE;
          fault_type_n = FT_NONE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n        = (state_n == SELECT) || (state_n == EJECT) || (state_n == WAIT_ACK);
    done_n        = (state_n == DONE);
    fault_n       = (state_n == FAULT);
    eject_big_n   = (state_n == EJECT) && sel_big_n;
    eject_small_n = (state_n == EJECT) && !sel_big_n;
  end

  // State register, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      sel_big     <= 1'b0;
      eject_cnt   <= '0;
      ack_timer   <= '0;
      ack_prev    <= 1'b0;
      remaining   <= 8'd0;
      coins_paid  <= 8'd0;
      inv_big     <= 8'd0;
      inv_small   <= 8'd0;
      fault_type  <= FT_NONE;
      eject_big   <= 1'b0;
      eject_small <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_n;
      sel_big     <= sel_big_n;
      eject_cnt   <= eject_cnt_n;
      ack_timer   <= ack_timer_n;
      ack_prev    <= hopper_ack;
      remaining   <= remaining_n;
      coins_paid  <= coins_paid_n;
      inv_big     <= inv_big_n;
      inv_small   <= inv_small_n;
      fault_type  <= fault_type_n;
      eject_big   <= eject_big_n;
      eject_small <= eject_small_n;
      busy        <= busy_n;
      done        <= done_n;
      fault       <= fault_n;
    end
  end

endmodule
